chroni_vram_arb: RTL and testbench

CHRONI_VRAM_ARB -- requirements
Module: chroni_vram_arb

---
 rtl/chroni_pkg.sv | 19 +
 rtl/chroni_vram_fifo.sv | 63 ++++++
 rtl/chroni_vram_arb.sv | 117 +++++++++++
 tb/tb_chroni_vram_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/chroni_pkg.sv
// Shared definitions for the Chroni VRAM arbiter: default bus widths and the
// CPU request record that is carried through the request queue.
package chroni_pkg;

  localparam int CHRONI_ADDR_W = 11;
  localparam int CHRONI_DATA_W = 8;

  typedef struct packed {
    logic                     we;
    logic [CHRONI_ADDR_W-1:0] addr;
    logic [CHRONI_DATA_W-1:0] wdata;
  } vram_req_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int chroni_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/chroni_vram_fifo.sv
// CPU request queue: power-of-two depth FIFO with a fall-through head so the
// arbiter can issue and pop the oldest entry in the same cycle.
module chroni_vram_fifo
  import chroni_pkg::*;
#(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_srst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = chroni_cnt_w(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/chroni_vram_arb.sv
// Single-port VRAM arbiter: video reads win every cycle they are requested,
// queued CPU reads/writes fill the remaining cycles in arrival order.
module chroni_vram_arb
  import chroni_pkg::*;
#(
  parameter int ADDR_W     = CHRONI_ADDR_W,
  parameter int DATA_W     = CHRONI_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              ovf_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [ENT_W-1:0]  w_push_ent;
  logic [ENT_W-1:0]  w_head;
  logic              w_head_we;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_wdata;
  logic              w_rvalid;

  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_pend;
  logic              r_ovf;

  // A simultaneous write+read request is stored as a write.
  assign w_req      = cpu_we | cpu_re;
  assign cpu_ready  = ~w_full;
  assign w_push     = w_req & ~w_full;
  assign w_push_ent = {cpu_we, cpu_addr, cpu_wdata};
  assign w_pop      = ~reset & ~vid_req & ~w_empty;

  assign w_head_we    = w_head[ENT_W-1];
  assign w_head_addr  = w_head[DATA_W +: ADDR_W];
  assign w_head_wdata = w_head[DATA_W-1:0];

  chroni_vram_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (vga_clk),
    .i_srst  (reset),
    .i_push  (w_push),
    .i_din   (w_push_ent),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    mem_addr  = r_last_addr;
    mem_we    = 1'b0;
    mem_wdata = r_last_wdata;
    if (vid_req) begin
      mem_addr = vid_addr;
    end else if (w_pop) begin
      mem_addr = w_head_addr;
      mem_we   = w_head_we;
      if (w_head_we) begin
        mem_wdata = w_head_wdata;
      end
    end
  end

  // Read data arrives combinationally the cycle after issue; the reset gate
  // suppresses a return for a read that was in flight when reset hit.
  assign w_rvalid   = r_rd_pend & ~reset;
  assign cpu_rvalid = w_rvalid;
  assign cpu_rdata  = w_rvalid ? mem_rdata : r_rdata;
  assign vid_data   = mem_rdata;
  assign ovf_err    = r_ovf;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_rdata      <= '0;
      r_rd_pend    <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_last_addr  <= mem_addr;
      r_last_wdata <= mem_wdata;
      r_rd_pend    <= w_pop & ~w_head_we;
      if (w_rvalid) begin
        r_rdata <= mem_rdata;
      end
      if (w_req & w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chroni_vram_arb.sv
// Scoreboard bench for chroni_vram_arb: accepted CPU requests are queued in a
// reference model and compared against the memory port as they are issued.
module tb_chroni_vram_arb;
  import chroni_pkg::*;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          vga_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          cpu_we = 1'b0;
  logic          cpu_re = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          ovf_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 vga_clk = ~vga_clk;

  chroni_vram_arb #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ovf_err    (ovf_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // External synchronous single-port VRAM.
  logic [DW-1:0] ram [2**AW];
  always @(posedge vga_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  vram_req_t     fq[$];
  int            tb_count = 0;
  bit            tb_ovf = 1'b0;
  bit            rd_pend = 1'b0;
  logic [DW-1:0] rd_exp = '0;
  logic [DW-1:0] tb_rdata = '0;
  bit            vid_prev = 1'b0;
  logic [DW-1:0] vid_exp = '0;
  logic [AW-1:0] tb_last_addr = '0;
  logic [DW-1:0] tb_last_wdata = '0;
  logic [DW-1:0] cmem [2**AW];

  task automatic cycle();
    bit        exp_pop;
    bit        acc;
    vram_req_t e;
    @(negedge vga_clk);
    if (reset) begin
      chk("rst_rvalid", cpu_rvalid, 0);
      fq.delete();
      tb_count = 0; tb_ovf = 0; rd_pend = 0; vid_prev = 0;
      tb_last_addr = '0; tb_last_wdata = '0; tb_rdata = '0;
    end else begin
      if (vid_prev) chk("vid_data", vid_data, vid_exp);
      chk("cpu_rvalid", cpu_rvalid, rd_pend);
      if (rd_pend) tb_rdata = rd_exp;
      chk("cpu_rdata", cpu_rdata, tb_rdata);
      chk("cpu_ready", cpu_ready, tb_count < DEPTH);
      chk("ovf_err", ovf_err, tb_ovf);
      exp_pop = !vid_req && tb_count > 0;
      rd_pend = 0;
      if (vid_req) begin
        chk("vid_mem_addr", mem_addr, vid_addr);
        chk("vid_mem_we", mem_we, 0);
        tb_last_addr = vid_addr;
      end else if (exp_pop) begin
        e = fq.pop_front();
        chk("cpu_mem_addr", mem_addr, e.addr);
        chk("cpu_mem_we", mem_we, e.we);
        if (e.we) begin
          chk("cpu_mem_wdata", mem_wdata, e.wdata);
          cmem[e.addr] = e.wdata;
          tb_last_wdata = e.wdata;
          $display("t=%0t wr addr=%03h data=%02h", $time, e.addr, e.wdata);
        end else begin
          rd_pend = 1;
          rd_exp = cmem[e.addr];
          $display("t=%0t rd addr=%03h expect=%02h", $time, e.addr, rd_exp);
        end
        tb_last_addr = e.addr;
      end else begin
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_addr", mem_addr, tb_last_addr);
        chk("idle_mem_wdata", mem_wdata, tb_last_wdata);
      end
      vid_prev = vid_req;
      vid_exp = cmem[vid_addr];
      acc = 0;
      if (cpu_we || cpu_re) begin
        if (tb_count < DEPTH) begin
          e.we = cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
          fq.push_back(e);
          acc = 1;
        end else begin
          tb_ovf = 1;
        end
      end
      tb_count = tb_count + int'(acc) - int'(exp_pop);
    end
    @(posedge vga_clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] va, input bit we, input bit re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    vid_req = v; vid_addr = va; cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = '0;
      cmem[i] = '0;
    end
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("reset_ready", cpu_ready, 1);
    chk("reset_rvalid", cpu_rvalid, 0);
    chk("reset_rdata", cpu_rdata, 0);
    chk("reset_ovf", ovf_err, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);

    // Single write with video idle, then preload the video address.
    drive(0, '0, 1, 0, 11'h400, 8'hA5);
    chk("wr_latency_we", mem_we, 1);
    chk("wr_latency_addr", mem_addr, 11'h400);
    chk("wr_latency_data", mem_wdata, 8'hA5);
    idle(1);
    drive(0, '0, 1, 0, 11'h401, 8'h77);
    idle(1);

    // Write then read back the same address.
    drive(0, '0, 1, 0, 11'h444, 8'h3C);
    drive(0, '0, 0, 1, 11'h444, 8'h00);
    idle(3);
    chk("wr_rd_rdata_hold", cpu_rdata, 8'h3C);

    // Fill under continuous video, overflow, then drain.
    for (int i = 0; i < 4; i++) drive(1, 11'h400, 1, 0, 11'(16 + i), 8'(8'h50 + i));
    chk("full_ready", cpu_ready, 0);
    drive(1, 11'h400, 1, 0, 11'h020, 8'hEE);
    chk("ovf_set", ovf_err, 1);
    idle(5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;

    // Reset one cycle after a CPU read is issued.
    drive(0, '0, 1, 0, 11'h020, 8'h55);
    idle(1);
    drive(0, '0, 0, 1, 11'h020, 8'h00);
    drive(0, '0, 1, 0, 11'h021, 8'h66);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("post_rst_ready", cpu_ready, 1);
    chk("post_rst_rvalid", cpu_rvalid, 0);
    idle(3);

    // Alternating video requests with writes pending.
    for (int i = 0; i < 3; i++) drive(1, 11'h401, 1, 0, 11'(48 + i), 8'(8'h90 + i));
    for (int i = 0; i < 8; i++) drive(i % 2 == 1, 11'h401, 0, 0, '0, '0);
    idle(2);

    // Full queue with push/pop overlap; occupancy returns to full without overflow.
    for (int i = 0; i < 4; i++) drive(1, 11'h401, 1, 0, 11'(64 + i), 8'(8'hC0 + i));
    drive(0, '0, 0, 0, '0, '0);
    drive(0, '0, 1, 0, 11'h044, 8'hC4);
    drive(1, 11'h401, 1, 0, 11'h045, 8'hC5);
    chk("refull_ready", cpu_ready, 0);
    chk("refull_ovf", ovf_err, 0);
    drive(1, 11'h401, 0, 0, '0, '0);
    idle(5);

    // Randomised traffic, including simultaneous we/re.
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 2) == 0, 11'(11'h100 + $urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            11'(11'h100 + $urandom_range(0, 7)), 8'($urandom));
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
